// File: rtl/prog_pkg.sv
// prog_pkg
// Shared definitions for the serial programmer link: the readback FSM state
// encoding, the UART frame length and the baud divider computation used by
// both the receive-side programmer and the readback transmitter.
package prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPT,
    SEND,
    CSUM,
    FIN
  } readback_state_t;

  // Start bit + 8 data bits + stop bit.
  localparam int FRAME_BITS = 10;

  // Clock cycles per serial bit, truncated toward zero.
  function automatic int calc_div(input int clk_rate_mhz, input int baud);
    return (clk_rate_mhz * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/prog_readback_tx_uart.sv
// uart_tx_byte
// Serializes one byte as a UART 8N1 frame. A load strobe may arrive in the
// same cycle as frame_done so frames can be chained with no idle gap.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   load         accept data and start a new frame
//   data[7:0]    byte to send, LSB first
//   tx           serial line, idle high
//   frame_done   high during the final cycle of the stop bit
module uart_tx_byte
  import prog_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_done
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
  localparam logic [3:0] BIT_LAST = 4'(FRAME_BITS - 1);

  logic [CW-1:0]         div_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shift;
  logic                  active;

  // The line is driven straight from the shift register, which resets and
  // refills with ones, so reset forces TX high immediately.
  assign tx         = shift[0];
  assign frame_done = active && (div_cnt == DIV_LAST) && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '1;
      active  <= 1'b0;
    end else if (load) begin
      shift   <= {1'b1, data, 1'b0};
      div_cnt <= '0;
      bit_cnt <= '0;
      active  <= 1'b1;
    end else if (active) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        shift   <= {1'b1, shift[FRAME_BITS-1:1]};
        if (bit_cnt == BIT_LAST) begin
          active  <= 1'b0;
          bit_cnt <= '0;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end else begin
        div_cnt <= div_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/prog_readback_tx.sv
// prog_readback_tx
// Reads a block of 32-bit words from memory and sends them little-endian
// over UART 8N1, followed by an 8-bit modular checksum of all data bytes.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             one-cycle request, honoured only in IDLE
//   base_addr[31:0]   byte address of the first word, [1:0] ignored
//   word_count[15:0]  number of words to send
//   busy              high from the cycle after an accepted start until done
//   done              one-cycle completion pulse
//   mem_addr[31:0]    word-aligned read address, held between reads
//   mem_read          one-cycle read strobe per word
//   mem_data[31:0]    read data, valid the cycle after mem_read
//   tx                serial output, idle high
module prog_readback_tx
  import prog_pkg::*;
#(
  parameter int CLK_RATE = 50,
  parameter int BAUD     = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_count,
  output logic        busy,
  output logic        done,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  input  logic [31:0] mem_data,
  output logic        tx
);

  localparam int DIV = calc_div(CLK_RATE, BAUD);

  readback_state_t state;
  logic [31:0]     addr;
  logic [15:0]     remaining;
  logic [31:0]     word;
  logic [1:0]      byte_idx;
  logic [7:0]      csum;

  logic            load;
  logic            data_load;
  logic [7:0]      load_byte;
  logic            frame_done;

  // Choose what the serializer gets next. The first byte of a word comes
  // straight off the memory bus during CAPT; later bytes come from the word
  // register, which shifts right so the next byte always sits in [15:8].
  // The checksum is loaded on the same edge the last data frame ends, so the
  // stream has no gap between the final data byte and the checksum.
  always_comb begin
    load      = 1'b0;
    data_load = 1'b0;
    load_byte = 8'h00;
    case (state)
      CAPT: begin
        load      = 1'b1;
        data_load = 1'b1;
        load_byte = mem_data[7:0];
      end
      SEND: begin
        if (frame_done) begin
          if (byte_idx != 2'd3) begin
            load      = 1'b1;
            data_load = 1'b1;
            load_byte = word[15:8];
          end else if (remaining == 16'd1) begin
            load      = 1'b1;
            load_byte = csum;
          end
        end
      end
      default: ;
    endcase
  end

  // Transfer sequencer with registered handshake and memory outputs.
  // The checksum accumulates each data byte as it is handed to the
  // serializer, so by the time the checksum frame is loaded it is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      word      <= '0;
      byte_idx  <= '0;
      csum      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_read  <= 1'b0;
      mem_addr  <= '0;
    end else begin
      mem_read <= 1'b0;
      done     <= 1'b0;
      if (data_load) csum <= csum + load_byte;
      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr & 32'hFFFF_FFFC;
            remaining <= word_count;
            busy      <= 1'b1;
            if (word_count == 16'd0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state    <= READ;
              mem_read <= 1'b1;
              mem_addr <= base_addr & 32'hFFFF_FFFC;
            end
          end
        end
        READ: state <= CAPT;
        CAPT: begin
          word     <= mem_data;
          byte_idx <= 2'd0;
          state    <= SEND;
        end
        SEND: begin
          if (frame_done) begin
            if (byte_idx != 2'd3) begin
              byte_idx <= byte_idx + 2'd1;
              word     <= {8'h00, word[31:8]};
            end else begin
              remaining <= remaining - 16'd1;
              addr      <= addr + 32'd4;
              if (remaining != 16'd1) begin
                state    <= READ;
                mem_read <= 1'b1;
                mem_addr <= addr + 32'd4;
              end else begin
                state <= CSUM;
              end
            end
          end
        end
        CSUM: begin
          if (frame_done) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          csum  <= 8'h00;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  uart_tx_byte #(
    .DIV(DIV)
  ) u_uart (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .data      (load_byte),
    .tx        (tx),
    .frame_done(frame_done)
  );

endmodule

// File: tb/tb_prog_readback_tx.sv
// tb_prog_readback_tx
// Scoreboard bench for prog_readback_tx. Expected read addresses and bytes
// are pushed when a transfer is started and popped as the monitors decode
// the memory strobe and the serial line. A short bit period keeps runs brief.
module tb_prog_readback_tx;

  localparam int CLK_RATE = 1;
  localparam int BAUD     = 100000;
  localparam int DIV      = 10;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr;
  logic [15:0] word_count;
  logic        busy;
  logic        done;
  logic [31:0] mem_addr;
  logic        mem_read;
  logic [31:0] mem_data;
  logic        tx;

  prog_readback_tx #(
    .CLK_RATE(CLK_RATE),
    .BAUD    (BAUD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_read  (mem_read),
    .mem_data  (mem_data),
    .tx        (tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       framing_ok;
  } rx_frame_t;

  typedef struct {
    int   len;
    logic level;
  } run_t;

  int          vectors;
  int          miscompares;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_addrs[$];
  rx_frame_t   rx_q[$];
  logic [31:0] rd_q[$];
  run_t        runs_q[$];
  int          done_cnt;
  bit          tx_low_seen;

  // Memory contents: one fixed word for the known-checksum case, a hash elsewhere.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hDEADBEEF;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic int exp_cycles(input int n);
    if (n == 0) return 1;
    return n * (2 + 40 * DIV) + 10 * DIV + 1;
  endfunction

  always @(posedge clk) if (mem_read) mem_data <= word_at(mem_addr);

  // Line, strobe and pulse monitors, sampled on the falling edge.
  int         mon_cnt;
  bit         mon_active;
  logic [9:0] mon_bits;
  int         run_len;
  logic       last_tx;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_active = 0;
      run_len    = 0;
      last_tx    = 1'b1;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (mem_read === 1'b1) rd_q.push_back(mem_addr);
      if (tx !== 1'b1) tx_low_seen = 1;
      if (tx !== last_tx) begin
        runs_q.push_back('{run_len, last_tx});
        run_len = 1;
        last_tx = tx;
      end else begin
        run_len++;
      end
      if (!mon_active) begin
        if (tx === 1'b0) begin
          mon_active = 1;
          mon_cnt    = 0;
        end
      end else begin
        mon_cnt++;
      end
      if (mon_active && (mon_cnt % DIV) == DIV / 2) begin
        mon_bits[mon_cnt / DIV] = tx;
        if (mon_cnt / DIV == 9) begin
          rx_q.push_back('{mon_bits[8:1], (mon_bits[9] === 1'b1) && (mon_bits[0] === 1'b0)});
          mon_active = 0;
        end
      end
    end
  end

  task automatic clear_queues();
    exp_bytes.delete();
    exp_addrs.delete();
    rx_q.delete();
    rd_q.delete();
    runs_q.delete();
  endtask

  // Push the expected address/byte stream, then pulse start for one cycle.
  task automatic start_xfer(input logic [31:0] b, input logic [15:0] n);
    logic [31:0] a;
    logic [31:0] w;
    logic [7:0]  s;
    logic [7:0]  by;
    a = b & 32'hFFFF_FFFC;
    s = 8'h00;
    for (int k = 0; k < int'(n); k++) begin
      exp_addrs.push_back(a);
      w = word_at(a);
      for (int j = 0; j < 4; j++) begin
        by = w[8*j +: 8];
        exp_bytes.push_back(by);
        s = s + by;
      end
      a = a + 32'd4;
    end
    if (n != 16'd0) exp_bytes.push_back(s);
    @(negedge clk);
    base_addr  = b;
    word_count = n;
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count falling edges after the start edge until done is seen.
  task automatic wait_done(input int budget, output int cyc, output bit timed_out);
    cyc = 0;
    timed_out = 1;
    while (cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) begin
        timed_out = 0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int d0;
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    repeat (3) @(negedge clk);
    vectors += 5;
    if (tx !== 1'b1) begin miscompares++; $display("[TB] FAIL reset tx: got %b need 1", tx); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset busy: got %b need 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset done: got %b need 0", done); end
    if (mem_read !== 1'b0) begin miscompares++; $display("[TB] FAIL reset mem_read: got %b need 0", mem_read); end
    if (mem_addr !== 32'h0) begin miscompares++; $display("[TB] FAIL reset mem_addr: got %h need 0", mem_addr); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    start_xfer(32'h100, 16'd1);
    repeat (6) @(negedge clk);
    vectors++;
    if (tx !== 1'b0) begin miscompares++; $display("[TB] FAIL midframe start bit: got tx %b need 0", tx); end
    #2 rst_n = 1'b0;
    #1;
    vectors += 3;
    if (tx !== 1'b1) begin miscompares++; $display("[TB] FAIL abort tx: got %b need 1", tx); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL abort busy: got %b need 0", busy); end
    if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL abort done: got %b need 0", done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (60 * DIV) @(negedge clk);
    vectors += 2;
    if (done_cnt !== d0) begin miscompares++; $display("[TB] FAIL post-abort done: got %0d pulses need 0", done_cnt - d0); end
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL post-abort busy: got %b need 0", busy); end
    clear_queues();
  endtask

  task automatic test_single_word();
    int cyc;
    bit to;
    logic [7:0] e;
    logic [31:0] ea;
    rx_frame_t f;
    clear_queues();
    start_xfer(32'h100, 16'd1);
    wait_done(5000, cyc, to);
    vectors++;
    if (to || cyc != exp_cycles(1)) begin
      miscompares++;
      $display("[TB] FAIL single latency: got %0d cycles (timeout %0b) need %0d", cyc, to, exp_cycles(1));
    end
    while (exp_addrs.size() > 0) begin
      ea = exp_addrs.pop_front();
      vectors++;
      if (rd_q.size() == 0) begin miscompares++; $display("[TB] FAIL single addr: got none need %h", ea); end
      else if (rd_q[0] !== ea) begin miscompares++; $display("[TB] FAIL single addr: got %h need %h", rd_q.pop_front(), ea); end
      else void'(rd_q.pop_front());
    end
    while (exp_bytes.size() > 0) begin
      e = exp_bytes.pop_front();
      vectors++;
      if (rx_q.size() == 0) begin miscompares++; $display("[TB] FAIL single byte: got none need %h", e); end
      else begin
        f = rx_q.pop_front();
        if (f.data !== e || !f.framing_ok) begin
          miscompares++;
          $display("[TB] FAIL single byte: got %h framing %0b need %h", f.data, f.framing_ok, e);
        end
      end
    end
    vectors++;
    if (rx_q.size() != 0 || rd_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL single extra: got %0d frames %0d reads need 0", rx_q.size(), rd_q.size());
    end
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL single busy fall: got %b need 0", busy); end
  endtask

  task automatic test_multi_word();
    int cyc;
    bit to;
    int bad_runs;
    logic [7:0] e;
    logic [31:0] ea;
    rx_frame_t f;
    run_t r;
    clear_queues();
    start_xfer(32'h103, 16'd3);
    wait_done(10000, cyc, to);
    vectors++;
    if (to || cyc != exp_cycles(3)) begin
      miscompares++;
      $display("[TB] FAIL multi latency: got %0d cycles (timeout %0b) need %0d", cyc, to, exp_cycles(3));
    end
    while (exp_addrs.size() > 0) begin
      ea = exp_addrs.pop_front();
      vectors++;
      if (rd_q.size() == 0) begin miscompares++; $display("[TB] FAIL multi addr: got none need %h", ea); end
      else if (rd_q[0] !== ea) begin miscompares++; $display("[TB] FAIL multi addr: got %h need %h", rd_q.pop_front(), ea); end
      else void'(rd_q.pop_front());
    end
    while (exp_bytes.size() > 0) begin
      e = exp_bytes.pop_front();
      vectors++;
      if (rx_q.size() == 0) begin miscompares++; $display("[TB] FAIL multi byte: got none need %h", e); end
      else begin
        f = rx_q.pop_front();
        if (f.data !== e || !f.framing_ok) begin
          miscompares++;
          $display("[TB] FAIL multi byte: got %h framing %0b need %h", f.data, f.framing_ok, e);
        end
      end
    end
    // Low runs must be whole bit periods; high runs may also carry the
    // two-cycle READ/CAPT gap appended to a word's last stop bit.
    bad_runs = 0;
    if (runs_q.size() > 0) void'(runs_q.pop_front());
    while (runs_q.size() > 0) begin
      r = runs_q.pop_front();
      if (r.level === 1'b0 && (r.len % DIV) != 0) bad_runs++;
      if (r.level === 1'b1 && (r.len % DIV) != 0 && (r.len % DIV) != 2) bad_runs++;
    end
    vectors++;
    if (bad_runs != 0) begin miscompares++; $display("[TB] FAIL multi bit width: got %0d bad runs need 0", bad_runs); end
  endtask

  task automatic test_zero_count();
    int cyc;
    bit to;
    clear_queues();
    tx_low_seen = 0;
    start_xfer(32'h500, 16'd0);
    wait_done(100, cyc, to);
    vectors += 2;
    if (to || cyc != 1) begin miscompares++; $display("[TB] FAIL zero latency: got %0d cycles (timeout %0b) need 1", cyc, to); end
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL zero busy: got %b need 1", busy); end
    repeat (3 * DIV) @(negedge clk);
    vectors += 2;
    if (rd_q.size() != 0) begin miscompares++; $display("[TB] FAIL zero reads: got %0d need 0", rd_q.size()); end
    if (tx_low_seen) begin miscompares++; $display("[TB] FAIL zero tx: got low need constant 1"); end
  endtask

  task automatic test_ignored_start();
    int cyc;
    bit to;
    int d0;
    logic [7:0] e;
    logic [31:0] ea;
    rx_frame_t f;
    clear_queues();
    d0 = done_cnt;
    start_xfer(32'h200, 16'd2);
    repeat (5 * DIV) @(negedge clk);
    base_addr  = 32'h300;
    word_count = 16'd5;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10000, cyc, to);
    vectors++;
    if (to) begin miscompares++; $display("[TB] FAIL ignored timeout: got none need done"); end
    while (exp_addrs.size() > 0) begin
      ea = exp_addrs.pop_front();
      vectors++;
      if (rd_q.size() == 0) begin miscompares++; $display("[TB] FAIL ignored addr: got none need %h", ea); end
      else if (rd_q[0] !== ea) begin miscompares++; $display("[TB] FAIL ignored addr: got %h need %h", rd_q.pop_front(), ea); end
      else void'(rd_q.pop_front());
    end
    while (exp_bytes.size() > 0) begin
      e = exp_bytes.pop_front();
      vectors++;
      if (rx_q.size() == 0) begin miscompares++; $display("[TB] FAIL ignored byte: got none need %h", e); end
      else begin
        f = rx_q.pop_front();
        if (f.data !== e || !f.framing_ok) begin
          miscompares++;
          $display("[TB] FAIL ignored byte: got %h framing %0b need %h", f.data, f.framing_ok, e);
        end
      end
    end
    repeat (60 * DIV) @(negedge clk);
    vectors++;
    if (done_cnt - d0 != 1 || rd_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL ignored done count: got %0d pulses %0d extra reads need 1 and 0", done_cnt - d0, rd_q.size());
    end
  endtask

  task automatic test_wrap();
    int cyc;
    bit to;
    logic [31:0] ea;
    logic [7:0] e;
    rx_frame_t f;
    clear_queues();
    start_xfer(32'hFFFF_FFFC, 16'd2);
    wait_done(10000, cyc, to);
    vectors++;
    if (to || cyc != exp_cycles(2)) begin
      miscompares++;
      $display("[TB] FAIL wrap latency: got %0d cycles (timeout %0b) need %0d", cyc, to, exp_cycles(2));
    end
    while (exp_addrs.size() > 0) begin
      ea = exp_addrs.pop_front();
      vectors++;
      if (rd_q.size() == 0) begin miscompares++; $display("[TB] FAIL wrap addr: got none need %h", ea); end
      else if (rd_q[0] !== ea) begin miscompares++; $display("[TB] FAIL wrap addr: got %h need %h", rd_q.pop_front(), ea); end
      else void'(rd_q.pop_front());
    end
    while (exp_bytes.size() > 0) begin
      e = exp_bytes.pop_front();
      vectors++;
      if (rx_q.size() == 0) begin miscompares++; $display("[TB] FAIL wrap byte: got none need %h", e); end
      else begin
        f = rx_q.pop_front();
        if (f.data !== e || !f.framing_ok) begin
          miscompares++;
          $display("[TB] FAIL wrap byte: got %h framing %0b need %h", f.data, f.framing_ok, e);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    bit to;
    logic [7:0] e;
    rx_frame_t f;
    clear_queues();
    start_xfer(32'h40, 16'd1);
    wait_done(5000, cyc, to);
    start_xfer(32'h80, 16'd1);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b accept: got busy %b need 1", busy); end
    wait_done(5000, cyc, to);
    vectors++;
    if (to || cyc != exp_cycles(1)) begin
      miscompares++;
      $display("[TB] FAIL b2b latency: got %0d cycles (timeout %0b) need %0d", cyc, to, exp_cycles(1));
    end
    while (exp_bytes.size() > 0) begin
      e = exp_bytes.pop_front();
      vectors++;
      if (rx_q.size() == 0) begin miscompares++; $display("[TB] FAIL b2b byte: got none need %h", e); end
      else begin
        f = rx_q.pop_front();
        if (f.data !== e || !f.framing_ok) begin
          miscompares++;
          $display("[TB] FAIL b2b byte: got %h framing %0b need %h", f.data, f.framing_ok, e);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    done_cnt    = 0;
    tx_low_seen = 0;
    mem_data    = '0;
    test_reset();
    test_single_word();
    test_multi_word();
    test_zero_count();
    test_ignored_start();
    test_wrap();
    test_back_to_back();
    repeat (5) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
